// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, mux, carry, flag and FSM encodings for the ALU execution stage
package alu_pkg;

    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_AND  = 4'd2;
    localparam logic [3:0] ALU_OP_OR   = 4'd3;
    localparam logic [3:0] ALU_OP_EOR  = 4'd4;
    localparam logic [3:0] ALU_OP_ASL  = 4'd5;
    localparam logic [3:0] ALU_OP_LSR  = 4'd6;
    localparam logic [3:0] ALU_OP_ROL  = 4'd7;
    localparam logic [3:0] ALU_OP_ROR  = 4'd8;
    localparam logic [3:0] ALU_OP_INC  = 4'd9;
    localparam logic [3:0] ALU_OP_DEC  = 4'd10;
    localparam logic [3:0] ALU_OP_PASS = 4'd11;

    localparam logic [2:0] SRC_A    = 3'd0;
    localparam logic [2:0] SRC_X    = 3'd1;
    localparam logic [2:0] SRC_Y    = 3'd2;
    localparam logic [2:0] SRC_DIN  = 3'd3;
    localparam logic [2:0] SRC_SP   = 3'd4;
    localparam logic [2:0] SRC_ZERO = 3'd5;
    localparam logic [2:0] SRC_ONES = 3'd6;

    localparam logic [1:0] CARRY_ZERO = 2'd0;
    localparam logic [1:0] CARRY_ONE  = 2'd1;
    localparam logic [1:0] CARRY_FLAG = 2'd2;
    localparam logic [1:0] CARRY_PORT = 2'd3;

    localparam int FLAG_N = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_BCD  = 2'd2;

    // ADD and SUB are the only ops that can take the decimal path and touch V
    function automatic logic is_arith(input logic [3:0] op);
        return op == ALU_OP_ADD || op == ALU_OP_SUB;
    endfunction

endpackage

// File: rtl/alu_if.sv
// alu_if: request/result bundle between the control FSM (master) and the ALU stage (slave)
interface alu_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [2:0]        src1_sel;
    logic [2:0]        src2_sel;
    logic [1:0]        carry_sel;
    logic [3:0]        alu_op;
    logic              decimal;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] x_reg;
    logic [DATA_W-1:0] y_reg;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] sp;
    logic              cin;
    logic              flag_we;
    logic [3:0]        flag_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] out;
    logic              cout;
    logic [3:0]        flags;

    modport master (
        output start, src1_sel, src2_sel, carry_sel, alu_op, decimal,
        output a_reg, x_reg, y_reg, data_in, sp, cin, flag_we, flag_in,
        input  busy, done, out, cout, flags
    );

    modport slave (
        input  start, src1_sel, src2_sel, carry_sel, alu_op, decimal,
        input  a_reg, x_reg, y_reg, data_in, sp, cin, flag_we, flag_in,
        output busy, done, out, cout, flags
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational binary ALU with per-nibble BCD adjust for ADD/SUB
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
)(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              c_i,
    input  logic [3:0]        op_i,
    input  logic              dec_i,
    output logic [DATA_W-1:0] res_o,
    output logic              cout_o,
    output logic              v_o,
    output logic              upd_c_o,
    output logic              upd_v_o
);
    localparam int MSB = DATA_W - 1;
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic              sub;
    logic [DATA_W-1:0] bp;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] bcd;
    logic              bcd_c;
    logic [4:0]        nib;
    logic              cy;

    assign sub = op_i == ALU_OP_SUB;
    assign bp  = sub ? ~b_i : b_i;
    assign sum = {1'b0, a_i} + {1'b0, bp} + {{DATA_W{1'b0}}, c_i};
    assign v_o = (a_i[MSB] == bp[MSB]) && (sum[MSB] != a_i[MSB]);

    // Decimal adjust, LSB nibble first: ADD corrects >9 by +6, SUB corrects a nibble borrow by -6
    always_comb begin
        bcd = '0;
        cy  = c_i;
        nib = '0;
        for (int i = 0; i < DATA_W / 4; i++) begin
            nib = {1'b0, a_i[i*4+:4]} + {1'b0, bp[i*4+:4]} + {4'b0, cy};
            cy  = sub ? nib[4] : nib > 5'd9;
            bcd[i*4+:4] = sub ? (nib[4] ? nib[3:0] : nib[3:0] - 4'd6) : (cy ? nib[3:0] + 4'd6 : nib[3:0]);
        end
        bcd_c = cy;
    end

    // Result selection; dec_i is only ever set for ADD/SUB by the caller
    always_comb begin
        res_o   = a_i;
        cout_o  = 1'b0;
        upd_c_o = 1'b0;
        upd_v_o = 1'b0;
        case (op_i)
            ALU_OP_ADD, ALU_OP_SUB: begin
                res_o   = dec_i ? bcd : sum[MSB:0];
                cout_o  = dec_i ? bcd_c : sum[DATA_W];
                upd_c_o = 1'b1;
                upd_v_o = 1'b1;
            end
            ALU_OP_AND: res_o = a_i & b_i;
            ALU_OP_OR:  res_o = a_i | b_i;
            ALU_OP_EOR: res_o = a_i ^ b_i;
            ALU_OP_ASL, ALU_OP_ROL: begin
                res_o   = {a_i[MSB-1:0], op_i == ALU_OP_ROL ? c_i : 1'b0};
                cout_o  = a_i[MSB];
                upd_c_o = 1'b1;
            end
            ALU_OP_LSR, ALU_OP_ROR: begin
                res_o   = {op_i == ALU_OP_ROR ? c_i : 1'b0, a_i[MSB:1]};
                cout_o  = a_i[0];
                upd_c_o = 1'b1;
            end
            ALU_OP_INC: res_o = a_i + ONE;
            ALU_OP_DEC: res_o = a_i - ONE;
            default:    res_o = a_i;
        endcase
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU stage with start/busy/done handshake, optional BCD cycle and N/V/Z/C flag register
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit DECIMAL_EN = 1'b1
)(
    input logic   clk,
    input logic   rst_n,
    alu_if.slave  bus
);
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] op1_q, op2_q, out_q;
    logic [3:0]        op_q, flags_q, flags_d;
    logic              cin_q, dec_q, cout_q, done_q;
    logic [DATA_W-1:0] src1, src2, res;
    logic              cin_sel, flag_c_now, accept, fin;
    logic              res_c, res_v, upd_c, upd_v;

    function automatic logic [DATA_W-1:0] pick(input logic [2:0] s, input logic [DATA_W-1:0] a, x, y, d, p);
        return s == SRC_A ? a : s == SRC_X ? x : s == SRC_Y ? y : s == SRC_DIN ? d : s == SRC_SP ? p : s == SRC_ONES ? '1 : '0;
    endfunction

    assign src1       = pick(bus.src1_sel, bus.a_reg, bus.x_reg, bus.y_reg, bus.data_in, bus.sp);
    assign src2       = pick(bus.src2_sel, bus.a_reg, bus.x_reg, bus.y_reg, bus.data_in, bus.sp);
    assign flag_c_now = bus.flag_we ? bus.flag_in[FLAG_C] : flags_q[FLAG_C];
    assign cin_sel    = bus.carry_sel == CARRY_ZERO ? 1'b0 : bus.carry_sel == CARRY_ONE ? 1'b1 : bus.carry_sel == CARRY_FLAG ? flag_c_now : bus.cin;
    assign accept     = state_q == ST_IDLE && bus.start;
    assign fin        = (state_q == ST_EXEC && !dec_q) || state_q == ST_BCD;

    alu_core #(.DATA_W(DATA_W)) u_core (
        .a_i     (op1_q),
        .b_i     (op2_q),
        .c_i     (cin_q),
        .op_i    (op_q),
        .dec_i   (dec_q),
        .res_o   (res),
        .cout_o  (res_c),
        .v_o     (res_v),
        .upd_c_o (upd_c),
        .upd_v_o (upd_v)
    );

    // Next state and next flags; a flag_we load overrides the done update on all four bits
    always_comb begin
        state_d = accept ? ST_EXEC : (state_q == ST_EXEC && dec_q) ? ST_BCD : fin ? ST_IDLE : state_q;
        flags_d = bus.flag_we ? bus.flag_in
                : fin ? {res[DATA_W-1], upd_v ? res_v : flags_q[FLAG_V], res == '0, upd_c ? res_c : flags_q[FLAG_C]}
                : flags_q;
    end

    // FSM and operand latch; everything the op needs is captured at the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            op_q    <= '0;
            cin_q   <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op1_q <= src1;
                op2_q <= src2;
                op_q  <= bus.alu_op;
                cin_q <= cin_sel;
                dec_q <= DECIMAL_EN && bus.decimal && is_arith(bus.alu_op);
            end
        end
    end

    // Result registers and done pulse, written only when an operation finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= fin;
            if (fin) begin
                out_q  <= res;
                cout_q <= res_c;
            end
        end
    end

    // Flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else        flags_q <= flags_d;
    end

    assign bus.busy  = state_q != ST_IDLE;
    assign bus.done  = done_q;
    assign bus.out   = out_q;
    assign bus.cout  = cout_q;
    assign bus.flags = flags_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vector table plus hand sequences for handshake, flag_we, reset and 16-bit width
module tb_alu_exec_unit;
    import alu_pkg::*;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b;
        logic [1:0] cs;
        logic       cin, dec;
        logic [3:0] fi;
        logic [7:0] eo;
        logic       ec, chk_c;
        logic [3:0] ef;
        int         lat;
    } vec_t;

    logic clk, rst_n;
    int   checks = 0, fails = 0;
    vec_t v[18];

    alu_if #(.DATA_W(8))  bus();
    alu_if #(.DATA_W(16)) bus16();

    alu_exec_unit #(.DATA_W(8), .DECIMAL_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_exec_unit #(.DATA_W(16), .DECIMAL_EN(1'b1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic load_flags(input logic [3:0] f);
        bus.flag_we = 1'b1;
        bus.flag_in = f;
        @(negedge clk);
        bus.flag_we = 1'b0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, b, input logic [1:0] cs, input logic ci, dec);
        bus.alu_op    = op;
        bus.a_reg     = a;
        bus.data_in   = b;
        bus.src1_sel  = SRC_A;
        bus.src2_sel  = SRC_DIN;
        bus.carry_sel = cs;
        bus.cin       = ci;
        bus.decimal   = dec;
        bus.start     = 1'b1;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [7:0] a, b, input logic [1:0] cs, input logic ci, dec, output int lat);
        int n;
        drive(op, a, b, cs, ci, dec);
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 6) begin
            @(negedge clk);
            n++;
        end
        lat = bus.done ? n - 1 : -1;
    endtask

    initial begin
        int lat, dn;
        v[0]  = '{ALU_OP_ADD,  8'h50, 8'h50, 2'd0, 1'b0, 1'b0, 4'b0000, 8'hA0, 1'b0, 1'b1, 4'b1100, 1};
        v[1]  = '{ALU_OP_ADD,  8'h58, 8'h46, 2'd1, 1'b0, 1'b1, 4'b0000, 8'h05, 1'b1, 1'b1, 4'b0101, 2};
        v[2]  = '{ALU_OP_ADD,  8'h58, 8'h46, 2'd1, 1'b0, 1'b0, 4'b0000, 8'h9F, 1'b0, 1'b1, 4'b1100, 1};
        v[3]  = '{ALU_OP_SUB,  8'h12, 8'h01, 2'd1, 1'b0, 1'b1, 4'b0000, 8'h11, 1'b1, 1'b1, 4'b0001, 2};
        v[4]  = '{ALU_OP_SUB,  8'h00, 8'h01, 2'd1, 1'b0, 1'b0, 4'b0000, 8'hFF, 1'b0, 1'b1, 4'b1000, 1};
        v[5]  = '{ALU_OP_AND,  8'hF0, 8'h3C, 2'd0, 1'b0, 1'b0, 4'b0101, 8'h30, 1'b0, 1'b0, 4'b0101, 1};
        v[6]  = '{ALU_OP_OR,   8'h0F, 8'h80, 2'd0, 1'b0, 1'b0, 4'b0010, 8'h8F, 1'b0, 1'b0, 4'b1000, 1};
        v[7]  = '{ALU_OP_EOR,  8'hFF, 8'hFF, 2'd0, 1'b0, 1'b0, 4'b0100, 8'h00, 1'b0, 1'b0, 4'b0110, 1};
        v[8]  = '{ALU_OP_ASL,  8'h81, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h02, 1'b1, 1'b1, 4'b0001, 1};
        v[9]  = '{ALU_OP_ROL,  8'h80, 8'h00, 2'd1, 1'b0, 1'b0, 4'b0000, 8'h01, 1'b1, 1'b1, 4'b0001, 1};
        v[10] = '{ALU_OP_INC,  8'hFF, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0101, 8'h00, 1'b0, 1'b0, 4'b0111, 1};
        v[11] = '{ALU_OP_DEC,  8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000, 8'hFF, 1'b0, 1'b0, 4'b1000, 1};
        v[12] = '{ALU_OP_PASS, 8'h7F, 8'h00, 2'd0, 1'b0, 1'b0, 4'b1011, 8'h7F, 1'b0, 1'b0, 4'b0001, 1};
        v[13] = '{4'd13,       8'h80, 8'h00, 2'd0, 1'b0, 1'b0, 4'b0000, 8'h80, 1'b0, 1'b0, 4'b1000, 1};
        v[14] = '{ALU_OP_ADD,  8'h01, 8'h01, 2'd3, 1'b1, 1'b0, 4'b0000, 8'h03, 1'b0, 1'b1, 4'b0000, 1};
        v[15] = '{ALU_OP_SUB,  8'h05, 8'h02, 2'd2, 1'b0, 1'b0, 4'b0000, 8'h02, 1'b1, 1'b1, 4'b0001, 1};
        v[16] = '{ALU_OP_ADD,  8'h99, 8'h01, 2'd0, 1'b0, 1'b1, 4'b0000, 8'h00, 1'b1, 1'b1, 4'b0011, 2};
        v[17] = '{ALU_OP_ROR,  8'h02, 8'h00, 2'd3, 1'b1, 1'b0, 4'b0000, 8'h81, 1'b0, 1'b1, 4'b1000, 1};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.src1_sel = '0; bus.src2_sel = '0; bus.carry_sel = '0; bus.alu_op = '0;
        bus.decimal = 1'b0; bus.a_reg = '0; bus.x_reg = 8'h11; bus.y_reg = 8'h22; bus.data_in = '0;
        bus.sp = 8'hFD; bus.cin = 1'b0; bus.flag_we = 1'b0; bus.flag_in = '0;
        bus16.start = 1'b0; bus16.src1_sel = '0; bus16.src2_sel = '0; bus16.carry_sel = '0; bus16.alu_op = '0;
        bus16.decimal = 1'b0; bus16.a_reg = '0; bus16.x_reg = '0; bus16.y_reg = '0; bus16.data_in = '0;
        bus16.sp = '0; bus16.cin = 1'b0; bus16.flag_we = 1'b0; bus16.flag_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_flags", bus.flags, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            load_flags(v[i].fi);
            do_op(v[i].op, v[i].a, v[i].b, v[i].cs, v[i].cin, v[i].dec, lat);
            chk($sformatf("v%0d_lat", i), lat, v[i].lat);
            chk($sformatf("v%0d_out", i), bus.out, v[i].eo);
            chk($sformatf("v%0d_flags", i), bus.flags, v[i].ef);
            if (v[i].chk_c) chk($sformatf("v%0d_cout", i), bus.cout, v[i].ec);
        end

        // LSR then ROR through the internal carry
        load_flags(4'b0000);
        do_op(ALU_OP_LSR, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0, lat);
        chk("lsr_out", bus.out, 8'h00);
        chk("lsr_flags", bus.flags, 4'b0011);
        chk("lsr_cout", bus.cout, 1);
        do_op(ALU_OP_ROR, 8'h00, 8'h00, CARRY_FLAG, 1'b0, 1'b0, lat);
        chk("ror_out", bus.out, 8'h80);
        chk("ror_flags", bus.flags, 4'b1000);
        chk("ror_cout", bus.cout, 0);

        // start held while busy is ignored
        drive(ALU_OP_ADD, 8'h01, 8'h01, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("busy_high", bus.busy, 1);
        dn = bus.done ? 1 : 0;
        @(negedge clk);
        bus.start = 1'b0;
        dn += bus.done ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            dn += bus.done ? 1 : 0;
        end
        chk("busy_start_dones", dn, 1);
        chk("busy_start_out", bus.out, 8'h02);

        // flag_we in the done cycle wins, then a back-to-back start in the done cycle
        load_flags(4'b0000);
        drive(ALU_OP_ADD, 8'h50, 8'h50, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flag_we = 1'b1;
        bus.flag_in = 4'b0001;
        @(negedge clk);
        bus.flag_we = 1'b0;
        chk("fwe_done", bus.done, 1);
        chk("fwe_flags", bus.flags, 4'b0001);
        chk("fwe_out", bus.out, 8'hA0);
        drive(ALU_OP_PASS, 8'h33, 8'h00, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy", bus.busy, 1);
        @(negedge clk);
        chk("b2b_done", bus.done, 1);
        chk("b2b_out", bus.out, 8'h33);

        // carry_sel=FLAG sees a flag_we load on the accept edge
        load_flags(4'b0000);
        drive(ALU_OP_ADD, 8'h10, 8'h01, CARRY_FLAG, 1'b0, 1'b0);
        bus.flag_we = 1'b1;
        bus.flag_in = 4'b0001;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flag_we = 1'b0;
        @(negedge clk);
        chk("cflag_same_edge_out", bus.out, 8'h12);

        // reset during EXEC aborts with no done
        load_flags(4'b1111);
        drive(ALU_OP_ADD, 8'h01, 8'h01, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_exec_busy", bus.busy, 0);
        chk("rst_exec_done", bus.done, 0);
        chk("rst_exec_flags", bus.flags, 0);
        chk("rst_exec_out", bus.out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            dn += bus.done ? 1 : 0;
        end
        chk("rst_exec_nodone", dn, 0);

        // 16-bit wrap
        bus16.alu_op = ALU_OP_ADD;
        bus16.a_reg = 16'hFFFF;
        bus16.data_in = 16'h0001;
        bus16.src1_sel = SRC_A;
        bus16.src2_sel = SRC_DIN;
        bus16.carry_sel = CARRY_ZERO;
        bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        @(negedge clk);
        chk("w16_done", bus16.done, 1);
        chk("w16_out", bus16.out, 16'h0000);
        chk("w16_cout", bus16.cout, 1);
        chk("w16_flags", bus16.flags, 4'b0011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
